// File: rtl/vernier_pt_mapper.sv
// vernier_pt_mapper: two-stage valid/ready pipeline mapping an ETS point index T to its ps offset.
// Define VERNIER_PT_MAPPER_ERRCNT_EN to build the delivered-error counter (cnt_err tied to 0 otherwise).
module vernier_pt_mapper #(
    parameter int IDX_W      = 7,
    parameter int OUT_W      = 32,
    parameter int STEP       = 80,
    parameter int BASE       = 10,
    parameter int FOLD_DIV   = 5,
    parameter int FOLD_PHASE = 3,
    parameter int FOLD_BASE  = 50,
    parameter int T_MIN      = 2,
    parameter int T_MAX      = 120
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W:0]   in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_offset,
    output logic             out_mark,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [31:0]      cnt_total,
    output logic [31:0]      cnt_err
);

    localparam logic [OUT_W-1:0] STEP_C      = OUT_W'(STEP);
    localparam logic [OUT_W-1:0] BASE_C      = OUT_W'(BASE);
    localparam logic [OUT_W-1:0] FOLD_BASE_C = OUT_W'(FOLD_BASE);

    logic             s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0] s1_t_q, s1_t_d;
    logic [IDX_W-1:0] s1_div_q, s1_div_d;
    logic             s1_mark_q, s1_mark_d;
    logic             s1_r_q, s1_r_d;
    logic             s1_f_q, s1_f_d;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_offset_q, out_offset_d;
    logic             out_mark_q, out_mark_d;
    logic             out_err_q, out_err_d;

    logic [31:0]      cnt_total_q, cnt_total_d;

    logic             accept, s1_advance, out_fire;
    logic [31:0]      t_ext;

    assign t_ext      = 32'(in_idx[IDX_W-1:0]);
    assign out_fire   = out_valid_q & out_ready;
    assign s1_advance = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready   = ~rst & (~s1_valid_q | s1_advance);
    assign accept     = in_valid & in_ready;

    always_comb begin
        s1_valid_d = accept | (s1_valid_q & ~s1_advance);
        s1_t_d     = s1_t_q;
        s1_div_d   = s1_div_q;
        s1_mark_d  = s1_mark_q;
        s1_r_d     = s1_r_q;
        s1_f_d     = s1_f_q;
        if (accept) begin
            s1_t_d    = in_idx[IDX_W-1:0];
            s1_mark_d = in_idx[IDX_W];
            s1_r_d    = (t_ext < 32'(T_MIN)) | (t_ext > 32'(T_MAX));
            s1_f_d    = (t_ext % 32'(FOLD_DIV)) == 32'(FOLD_PHASE);
            // Quotient only matters for folded points, which always satisfy T >= FOLD_PHASE
            s1_div_d  = (t_ext >= 32'(FOLD_PHASE))
                        ? IDX_W'((t_ext - 32'(FOLD_PHASE)) / 32'(FOLD_DIV)) : '0;
        end
    end

    always_comb begin
        out_valid_d  = s1_advance | (out_valid_q & ~out_ready);
        out_offset_d = out_offset_q;
        out_mark_d   = out_mark_q;
        out_err_d    = out_err_q;
        if (s1_advance) begin
            out_mark_d = s1_mark_q;
            out_err_d  = s1_r_q;
            if (s1_r_q)
                out_offset_d = '0;
            else if (s1_f_q)
                out_offset_d = FOLD_BASE_C + STEP_C * OUT_W'(s1_div_q);
            else
                out_offset_d = STEP_C * OUT_W'(s1_t_q) + BASE_C;
        end
    end

    always_comb begin
        cnt_total_d = cnt_total_q;
        if (cnt_clr)
            cnt_total_d = '0;
        else if (out_fire)
            cnt_total_d = cnt_total_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_t_q       <= '0;
            s1_div_q     <= '0;
            s1_mark_q    <= 1'b0;
            s1_r_q       <= 1'b0;
            s1_f_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_offset_q <= '0;
            out_mark_q   <= 1'b0;
            out_err_q    <= 1'b0;
            cnt_total_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_t_q       <= s1_t_d;
            s1_div_q     <= s1_div_d;
            s1_mark_q    <= s1_mark_d;
            s1_r_q       <= s1_r_d;
            s1_f_q       <= s1_f_d;
            out_valid_q  <= out_valid_d;
            out_offset_q <= out_offset_d;
            out_mark_q   <= out_mark_d;
            out_err_q    <= out_err_d;
            cnt_total_q  <= cnt_total_d;
        end
    end

`ifdef VERNIER_PT_MAPPER_ERRCNT_EN
    logic [31:0] cnt_err_q, cnt_err_d;

    always_comb begin
        cnt_err_d = cnt_err_q;
        if (cnt_clr)
            cnt_err_d = '0;
        else if (out_fire & out_err_q)
            cnt_err_d = cnt_err_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_err_q <= '0;
        else
            cnt_err_q <= cnt_err_d;
    end

    assign cnt_err = cnt_err_q;
`else
    assign cnt_err = '0;
`endif

    assign out_valid  = out_valid_q;
    assign out_offset = out_offset_q;
    assign out_mark   = out_mark_q;
    assign out_err    = out_err_q;
    assign cnt_total  = cnt_total_q;

endmodule

// File: tb/tb_vernier_pt_mapper.sv
// Scoreboard bench for vernier_pt_mapper: driver pushes expected results, negedge monitor pops and compares.
module tb_vernier_pt_mapper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_idx = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_offset;
    logic        out_mark;
    logic        out_err;
    logic        cnt_clr = 1'b0;
    logic [31:0] cnt_total;
    logic [31:0] cnt_err;

    vernier_pt_mapper dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_offset(out_offset),
        .out_mark(out_mark), .out_err(out_err),
        .cnt_clr(cnt_clr), .cnt_total(cnt_total), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] off;
        logic        mark;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   first_acc = 0;
    int   last_acc = 0;
    int   full_seen = 0;
    bit   lat_chk = 1'b0;
    bit   stall_mode = 1'b0;

`ifdef VERNIER_PT_MAPPER_ERRCNT_EN
    localparam logic [31:0] ERR_EXP = 32'd2;
`else
    localparam logic [31:0] ERR_EXP = 32'd0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] m_off(input int t);
        if (t < 2 || t > 120) return 32'd0;
        if (t % 5 == 3) return 32'(50 + 80 * ((t - 3) / 5));
        return 32'(80 * t + 10);
    endfunction

    task automatic send(input logic [7:0] idx, input logic [31:0] off, input logic err);
        int n = 0;
        in_valid = 1'b1;
        in_idx   = idx;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'(n), 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        sb.push_back('{off, idx[7], err, cyc});
        last_acc = cyc;
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: handshake-accurate checks sampled mid-cycle
    initial begin
        exp_t        e;
        bit          stall_prev = 1'b0;
        logic [31:0] h_off = '0;
        logic [1:0]  h_flags = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                chk("in_ready", 32'(in_ready), 32'(!(sb.size() >= 2 && !out_ready)));
                if (!in_ready) full_seen++;
                if (stall_prev) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_offset", out_offset, h_off);
                    chk("hold_flags", 32'({out_mark, out_err}), 32'(h_flags));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", out_offset, 32'd0);
                        chk("unexpected_output_count", 32'd1, 32'(sb.size()));
                    end else begin
                        e = sb.pop_front();
                        chk("offset", out_offset, e.off);
                        chk("mark", 32'(out_mark), 32'(e.mark));
                        chk("err", 32'(out_err), 32'(e.err));
                        if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'd2);
                    end
                end
                stall_prev = out_valid && !out_ready;
                h_off      = out_offset;
                h_flags    = {out_mark, out_err};
            end
        end
    end

    // out_ready pattern 1,0,0,1 while stalling is enabled
    initial begin
        logic [3:0] pat = 4'b1001;
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                out_ready = pat[ph];
                ph = (ph + 1) % 4;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_offset", out_offset, 32'd0);
        chk("rst_flags", 32'({out_mark, out_err}), 32'd0);
        chk("rst_cnt_total", cnt_total, 32'd0);
        chk("rst_cnt_err", cnt_err, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);

        // Directed singles against the legacy table
        lat_chk = 1'b1;
        send(8'd2,   32'd170,  1'b0); drain();
        send(8'd3,   32'd50,   1'b0); drain();
        send(8'd8,   32'd130,  1'b0); drain();
        send(8'd118, 32'd1890, 1'b0); drain();
        send(8'd120, 32'd9610, 1'b0); drain();
        send(8'h81,  32'd0,    1'b1); drain();
        send(8'd121, 32'd0,    1'b1); drain();
        chk("cnt_total_singles", cnt_total, 32'd7);
        chk("cnt_err_singles", cnt_err, ERR_EXP);

        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_total", cnt_total, 32'd0);
        chk("clr_err", cnt_err, 32'd0);

        // Back-to-back stream, no backpressure
        for (int t = 2; t <= 120; t++) begin
            send(8'(t), m_off(t), 1'b0);
            if (t == 2) first_acc = last_acc;
        end
        chk("stream_accept_span", 32'(last_acc - first_acc), 32'd118);
        drain();
        chk("cnt_total_stream", cnt_total, 32'd119);

        // Same stream under 1,0,0,1 backpressure, marker toggling
        lat_chk    = 1'b0;
        full_seen  = 0;
        stall_mode = 1'b1;
        for (int t = 2; t <= 120; t++) begin
            logic [7:0] idx;
            idx = 8'(t);
            idx[7] = idx[0];
            send(idx, m_off(t), 1'b0);
        end
        drain();
        stall_mode = 1'b0;
        out_ready  = 1'b1;
        chk("cnt_total_stall", cnt_total, 32'd238);
        chk("full_seen", 32'(full_seen != 0), 32'd1);

        // Reset with two items in flight
        out_ready = 1'b0;
        send(8'd10, 32'd810, 1'b0);
        send(8'd11, 32'd890, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_cnt_total", cnt_total, 32'd0);
        chk("midrst_cnt_err", cnt_err, 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_release_in_ready", 32'(in_ready), 32'd1);
        lat_chk = 1'b1;
        send(8'd4, 32'd330, 1'b0);
        drain();
        chk("cnt_total_after_rst", cnt_total, 32'd1);

        // Clear coinciding with an output handshake
        send(8'd5, 32'd410, 1'b0);
        @(posedge clk);
        #1;
        chk("clr_hs_valid", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_hs_total", cnt_total, 32'd0);
        send(8'd6, 32'd490, 1'b0);
        drain();
        chk("clr_resume_total", cnt_total, 32'd1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
